// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: lets N_REQ requesters take turns writing one shared
// WIDTH-bit register. A pending request is granted for one cycle (LOAD),
// the winner's data is captured, and the value is then held for
// HOLD_CYCLES cycles (HOLD) before the next arbitration in IDLE.
//
// Optional build macro ARB_FIXED_PRI_EN: when defined, the lowest set
// request index always wins. The round-robin pointer keeps updating but
// plays no part in the choice. When undefined, arbitration is round-robin
// starting after the last winner.
module reg_share_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     din,
    output logic [N_REQ-1:0]           gnt,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [N_REQ-1:0] ONE_HOT_ZERO = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [OW-1:0]    LAST_INIT    = OW'(N_REQ - 1);
    localparam logic [HW-1:0]    HOLD_INIT    = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_r;
    logic [N_REQ-1:0]    gnt_r;
    logic [WIDTH-1:0]    dout_r;
    logic                dout_valid_r;
    logic [OW-1:0]       owner_r;
    logic [OW-1:0]       last_r;
    logic [HW-1:0]       hold_cnt_r;
    logic [OW-1:0]       search_base_s;
    logic [OW-1:0]       winner_s;

    // Scan requests starting just after 'base', wrapping modulo N_REQ;
    // the first set bit encountered wins. Returns 0 when nothing is set.
    function automatic logic [OW-1:0] pick_winner(
        input logic [N_REQ-1:0] r,
        input logic [OW-1:0]    base
    );
        logic [OW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(base) + k) % N_REQ;
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

`ifdef ARB_FIXED_PRI_EN
    // Starting the scan after index N_REQ-1 makes the lowest set index win.
    assign search_base_s = LAST_INIT;
`else
    // Round-robin: the scan starts just after the previous winner.
    assign search_base_s = last_r;
`endif

    // Arbitration result for the current request vector.
    always_comb begin
        winner_s = pick_winner(req, search_base_s);
    end

    // Control FSM together with its registered outputs.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            gnt_r        <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            owner_r      <= '0;
            last_r       <= LAST_INIT;
            hold_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req != '0) begin
                        gnt_r   <= ONE_HOT_ZERO << winner_s;
                        owner_r <= winner_s;
                        last_r  <= winner_s;
                        state_r <= LOAD;
                    end else begin
                        gnt_r   <= '0;
                    end
                end
                LOAD: begin
                    // Capture is committed by the grant; req is not re-checked.
                    dout_r       <= din[owner_r*WIDTH +: WIDTH];
                    dout_valid_r <= 1'b1;
                    gnt_r        <= '0;
                    hold_cnt_r   <= HOLD_INIT;
                    state_r      <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt_r == '0) begin
                        state_r    <= IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - HW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= '0;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign owner      = owner_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter: directed scenarios followed by
// random traffic, all compared each cycle against a cycle-level model that
// tracks "grant pending capture" and "hold cycles remaining".
module tb_reg_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int OW = $clog2(N);

    logic               clock;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N*W-1:0]     din;
    logic [N-1:0]       gnt;
    logic [W-1:0]       dout;
    logic               dout_valid;
    logic [OW-1:0]      owner;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_dout;
    logic         m_valid;
    int           m_owner;
    int           m_last;
    bit           m_loading;
    int           m_remaining;

    reg_share_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(H)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .owner      (owner),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        int start;
        int idx;
        bit found;
        if (!rst_n) begin
            m_gnt = '0; m_dout = '0; m_valid = 1'b0; m_owner = 0;
            m_last = N - 1; m_loading = 1'b0; m_remaining = 0;
        end else if (m_loading) begin
            m_dout      = din[m_owner*W +: W];
            m_valid     = 1'b1;
            m_gnt       = '0;
            m_loading   = 1'b0;
            m_remaining = H;
        end else if (m_remaining > 0) begin
            m_remaining--;
        end else if (req != '0) begin
`ifdef ARB_FIXED_PRI_EN
            start = 0;
`else
            start = (m_last + 1) % N;
`endif
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (start + k) % N;
                if (!found && req[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            m_last    = m_owner;
            m_gnt     = '0;
            m_gnt[m_owner] = 1'b1;
            m_loading = 1'b1;
        end
    endtask

    // One clock: update model, let the edge happen, then compare away from it.
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        if (rst_n === 1'b1 || rst_n === 1'b0) begin
            check("gnt",        32'(gnt),        32'(m_gnt));
            check("dout",       32'(dout),       32'(m_dout));
            check("dout_valid", 32'(dout_valid), 32'(m_valid));
            check("owner",      32'(owner),      32'(m_owner));
            check("busy",       32'(busy),       32'(m_loading || (m_remaining > 0)));
        end
    endtask

    task automatic set_din(input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] d2, input logic [W-1:0] d3);
        din = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        set_din(8'h98, 8'hFC, 8'h9E, 8'h81);

        // Reset state
        do_reset();
        check("rst_gnt",   32'(gnt),        32'h0);
        check("rst_dout",  32'(dout),       32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_busy",  32'(busy),       32'h0);

        // Single requester 0
        req = 4'b0001;
        tick();
        check("single_gnt", 32'(gnt), 32'h1);
        tick();
        check("single_dout",  32'(dout),  32'h98);
        check("single_owner", 32'(owner), 32'h0);
        check("single_gnt_drop", 32'(gnt), 32'h0);
        for (int i = 0; i < 6; i++) tick();

        // Round-robin with all requesting
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 22; i++) tick();

        // Late request arriving in LOAD; requester 0 drops req during LOAD
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0100;
        tick();
        check("dropped_capture", 32'(dout), 32'h98);
        for (int i = 0; i < 6; i++) tick();
        check("late_owner", 32'(owner), 32'h2);

        // Reset in the middle of HOLD, then req=1010 goes to requester 1
        req = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_dout",  32'(dout),       32'h0);
        check("midrst_valid", 32'(dout_valid), 32'h0);
        rst_n = 1'b1;
        req = 4'b1010;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 12; i++) tick();

        // Idle retention after one capture of requester 1
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 12; i++) tick();
        check("idle_dout", 32'(dout), 32'hFC);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            req   = N'($urandom_range(0, (1 << N) - 1));
            din   = $urandom;
            rst_n = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
